// File: rtl/oric_mem_arbiter.sv
// Oric memory arbiter: turns core RAM/ROM activity and data_io download writes
// into toggle-handshake requests on an SDRAM port, one request in flight at a time.
// Events that arrive while a request is outstanding wait in per-source slots.
`timescale 1ns/1ps

module oric_mem_arbiter #(
    parameter logic RAM_BASE = 1'b1
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [16:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        ram_cs,
    input  logic        ram_oe,
    input  logic        ram_we,
    input  logic [15:0] ram_ad,
    input  logic [7:0]  ram_d,
    input  logic        rom_cs,
    input  logic        rom_ext_cs,
    input  logic [15:0] rom_ad,
    input  logic        atmos,
    output logic        port_req,
    input  logic        port_ack,
    output logic [15:0] port_a,
    output logic [1:0]  port_ds,
    output logic        port_we,
    output logic [15:0] port_d,
    input  logic [15:0] port_q,
    output logic [7:0]  ram_q,
    output logic [7:0]  rom_q,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;

    // previous-cycle copies of the selects and addresses used for edge/change detection
    logic        r_ramRdPrev;
    logic        r_ramWrPrev;
    logic        r_romSelPrev;
    logic [15:0] r_ramAdPrev;
    logic [15:0] r_romAdPrev;

    // pending slots, one per source
    logic        r_dlValid;
    logic [16:0] r_dlAddr;
    logic [7:0]  r_dlData;
    logic        r_ramValid;
    logic [16:0] r_ramAddr;
    logic [7:0]  r_ramData;
    logic        r_ramWe;
    logic        r_romValid;
    logic [16:0] r_romAddr;

    // request currently presented to the SDRAM port
    logic        r_portReq;
    logic [15:0] r_portA;
    logic [1:0]  r_portDs;
    logic        r_portWe;
    logic [15:0] r_portD;
    logic        r_selRom;
    logic        r_selByte;
    logic [7:0]  r_ramQ;
    logic [7:0]  r_romQ;

    logic        w_ramRdSel;
    logic        w_ramWrSel;
    logic        w_romSel;
    logic        w_dlEv;
    logic        w_ramWrEv;
    logic        w_ramRdEv;
    logic        w_romEv;
    logic        w_ramPend;
    logic        w_romPend;
    logic [16:0] w_ramByteAddr;
    logic [16:0] w_romByteAddr;
    logic        w_issueDl;
    logic        w_issueRam;
    logic        w_issueRom;
    logic        w_issue;
    logic        w_done;
    logic [16:0] w_selAddr;
    logic [7:0]  w_selData;
    logic        w_selWe;
    logic        w_selRom;
    logic [7:0]  w_readByte;

    assign w_ramRdSel    = ram_cs & ram_oe;
    assign w_ramWrSel    = ram_cs & ram_we;
    assign w_romSel      = rom_cs | rom_ext_cs;

    assign w_ramByteAddr = {RAM_BASE, ram_ad};
    assign w_romByteAddr = rom_cs ? {2'b00, atmos, rom_ad[13:0]} : {4'b0100, rom_ad[12:0]};

    // Core activity is ignored during a download so stale CPU traffic cannot land in SDRAM
    assign w_dlEv    = ioctl_download & ioctl_wr;
    assign w_ramWrEv = ~ioctl_download & w_ramWrSel & ~r_ramWrPrev;
    assign w_ramRdEv = ~ioctl_download & w_ramRdSel & (~r_ramRdPrev | (ram_ad != r_ramAdPrev));
    assign w_romEv   = ~ioctl_download & w_romSel & (~r_romSelPrev | (rom_ad != r_romAdPrev));

    assign w_ramPend = r_ramValid & ~ioctl_download;
    assign w_romPend = r_romValid & ~ioctl_download;

    assign w_issue    = w_issueDl | w_issueRam | w_issueRom;
    assign w_readByte = r_selByte ? port_q[15:8] : port_q[7:0];

    // State register; SYNC after reset realigns the request toggle with the ack
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state plus slot selection: download beats RAM beats ROM
    always_comb begin
        w_stateNext = r_state;
        w_issueDl   = 1'b0;
        w_issueRam  = 1'b0;
        w_issueRom  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_SYNC: begin
                w_stateNext = ST_IDLE;
            end
            ST_IDLE: begin
                if (r_dlValid) begin
                    w_issueDl = 1'b1;
                end else if (w_ramPend) begin
                    w_issueRam = 1'b1;
                end else if (w_romPend) begin
                    w_issueRom = 1'b1;
                end
                if (r_dlValid | w_ramPend | w_romPend) begin
                    w_stateNext = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (port_ack == r_portReq) begin
                    w_done      = 1'b1;
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext = ST_SYNC;
            end
        endcase
    end

    // Mux the winning slot onto the request fields
    always_comb begin
        w_selAddr = r_dlAddr;
        w_selData = r_dlData;
        w_selWe   = 1'b1;
        w_selRom  = 1'b0;
        if (w_issueRam) begin
            w_selAddr = r_ramAddr;
            w_selData = r_ramData;
            w_selWe   = r_ramWe;
        end else if (w_issueRom) begin
            w_selAddr = r_romAddr;
            w_selData = 8'h00;
            w_selWe   = 1'b0;
            w_selRom  = 1'b1;
        end
    end

    // Remember last-cycle selects and addresses for edge and change detection
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_ramRdPrev  <= 1'b0;
            r_ramWrPrev  <= 1'b0;
            r_romSelPrev <= 1'b0;
            r_ramAdPrev  <= 16'h0000;
            r_romAdPrev  <= 16'h0000;
        end else begin
            r_ramRdPrev  <= w_ramRdSel;
            r_ramWrPrev  <= w_ramWrSel;
            r_romSelPrev <= w_romSel;
            r_ramAdPrev  <= ram_ad;
            r_romAdPrev  <= rom_ad;
        end
    end

    // Slot update: a fresh event always wins over the drain of the same slot
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_dlValid  <= 1'b0;
            r_dlAddr   <= 17'h00000;
            r_dlData   <= 8'h00;
            r_ramValid <= 1'b0;
            r_ramAddr  <= 17'h00000;
            r_ramData  <= 8'h00;
            r_ramWe    <= 1'b0;
            r_romValid <= 1'b0;
            r_romAddr  <= 17'h00000;
        end else begin
            if (w_dlEv) begin
                r_dlValid <= 1'b1;
                r_dlAddr  <= ioctl_addr;
                r_dlData  <= ioctl_dout;
            end else if (w_issueDl) begin
                r_dlValid <= 1'b0;
            end

            if (ioctl_download) begin
                r_ramValid <= 1'b0;
            end else if (w_ramWrEv) begin
                r_ramValid <= 1'b1;
                r_ramAddr  <= w_ramByteAddr;
                r_ramData  <= ram_d;
                r_ramWe    <= 1'b1;
            end else if (w_ramRdEv) begin
                r_ramValid <= 1'b1;
                r_ramAddr  <= w_ramByteAddr;
                r_ramWe    <= 1'b0;
            end else if (w_issueRam) begin
                r_ramValid <= 1'b0;
            end

            if (ioctl_download) begin
                r_romValid <= 1'b0;
            end else if (w_romEv) begin
                r_romValid <= 1'b1;
                r_romAddr  <= w_romByteAddr;
            end else if (w_issueRom) begin
                r_romValid <= 1'b0;
            end
        end
    end

    // Launch requests, resync the toggle, and capture read bytes on completion
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_portReq <= 1'b0;
            r_portA   <= 16'h0000;
            r_portDs  <= 2'b00;
            r_portWe  <= 1'b0;
            r_portD   <= 16'h0000;
            r_selRom  <= 1'b0;
            r_selByte <= 1'b0;
            r_ramQ    <= 8'h00;
            r_romQ    <= 8'h00;
        end else begin
            if (r_state == ST_SYNC) begin
                r_portReq <= port_ack;
            end
            if (w_issue) begin
                r_portReq <= ~r_portReq;
                r_portA   <= w_selAddr[16:1];
                r_portDs  <= w_selWe ? (w_selAddr[0] ? 2'b10 : 2'b01) : 2'b11;
                r_portWe  <= w_selWe;
                r_portD   <= {w_selData, w_selData};
                r_selRom  <= w_selRom;
                r_selByte <= w_selAddr[0];
            end
            if (w_done && !r_portWe) begin
                if (r_selRom) begin
                    r_romQ <= w_readByte;
                end else begin
                    r_ramQ <= w_readByte;
                end
            end
        end
    end

    assign port_req = r_portReq;
    assign port_a   = r_portA;
    assign port_ds  = r_portDs;
    assign port_we  = r_portWe;
    assign port_d   = r_portD;
    assign ram_q    = r_ramQ;
    assign rom_q    = r_romQ;

    // Busy is held low while reset is asserted so every output reads zero in reset
    assign busy = reset_n & ((r_state != ST_IDLE) | r_dlValid | r_ramValid | r_romValid);

endmodule

// File: tb/tb_oric_mem_arbiter.sv
// Scoreboard bench for oric_mem_arbiter: expected SDRAM requests are queued as
// stimulus is issued and a monitor checks each request as port_req toggles.
`timescale 1ns/1ps

module tb_oric_mem_arbiter;

    typedef struct packed {
        logic        dl;
        logic        wr;
        logic [16:0] ioAddr;
        logic [7:0]  ioData;
        logic        ramCs;
        logic        ramOe;
        logic        ramWe;
        logic [15:0] ramAd;
        logic [7:0]  ramD;
        logic        romCs;
        logic        romExtCs;
        logic [15:0] romAd;
        logic        atmos;
    } vec_t;

    typedef struct packed {
        logic [15:0] a;
        logic [1:0]  ds;
        logic        we;
        logic [15:0] d;
    } req_t;

    logic        clk_sys;
    logic        reset_n;
    logic        port_req;
    logic        port_ack;
    logic [15:0] port_a;
    logic [1:0]  port_ds;
    logic        port_we;
    logic [15:0] port_d;
    logic [15:0] port_q;
    logic [7:0]  ram_q;
    logic [7:0]  rom_q;
    logic        busy;

    vec_t        stim;
    req_t        expQ[$];
    logic [15:0] respQ[$];
    int          compared   = 0;
    int          mismatched = 0;
    bit          monitorEnable = 1'b0;
    bit          respEnable    = 1'b0;
    bit          holdAck       = 1'b0;

    oric_mem_arbiter #(.RAM_BASE(1'b1)) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .ioctl_download(stim.dl),
        .ioctl_wr      (stim.wr),
        .ioctl_addr    (stim.ioAddr),
        .ioctl_dout    (stim.ioData),
        .ram_cs        (stim.ramCs),
        .ram_oe        (stim.ramOe),
        .ram_we        (stim.ramWe),
        .ram_ad        (stim.ramAd),
        .ram_d         (stim.ramD),
        .rom_cs        (stim.romCs),
        .rom_ext_cs    (stim.romExtCs),
        .rom_ad        (stim.romAd),
        .atmos         (stim.atmos),
        .port_req      (port_req),
        .port_ack      (port_ack),
        .port_a        (port_a),
        .port_ds       (port_ds),
        .port_we       (port_we),
        .port_d        (port_d),
        .port_q        (port_q),
        .ram_q         (ram_q),
        .rom_q         (rom_q),
        .busy          (busy)
    );

    // 100 MHz clock
    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int cycles);
        stim = v;
        repeat (cycles) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic waitIdle(input string name, input int limit);
        int n = 0;
        @(negedge clk_sys);
        while (busy !== 1'b0 && n < limit) begin
            @(negedge clk_sys);
            n++;
        end
        checkOutput(name, 32'(busy), 32'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_port_req"}, 32'(port_req), 32'd0);
        checkOutput({tag, "_port_a"},   32'(port_a),   32'd0);
        checkOutput({tag, "_port_ds"},  32'(port_ds),  32'd0);
        checkOutput({tag, "_port_we"},  32'(port_we),  32'd0);
        checkOutput({tag, "_port_d"},   32'(port_d),   32'd0);
        checkOutput({tag, "_ram_q"},    32'(ram_q),    32'd0);
        checkOutput({tag, "_rom_q"},    32'(rom_q),    32'd0);
        checkOutput({tag, "_busy"},     32'(busy),     32'd0);
    endtask

    function automatic req_t mkReq(input logic [15:0] a, input logic [1:0] ds, input logic we, input logic [15:0] d);
        req_t r;
        r.a  = a;
        r.ds = ds;
        r.we = we;
        r.d  = d;
        return r;
    endfunction

    // SDRAM model: acknowledges each request two cycles after it appears, returning the next queued word
    initial begin
        int waitCnt;
        waitCnt  = 0;
        port_ack = 1'b1;
        port_q   = 16'h0000;
        forever begin
            @(negedge clk_sys);
            if (respEnable && !holdAck && reset_n && (port_req != port_ack)) begin
                waitCnt++;
                if (waitCnt >= 2) begin
                    if (respQ.size() > 0) begin
                        port_q = respQ.pop_front();
                    end else begin
                        port_q = 16'h0000;
                    end
                    port_ack = port_req;
                    waitCnt  = 0;
                end
            end else begin
                waitCnt = 0;
            end
        end
    end

    // Monitor: every toggle of port_req is a new request and is checked against the queue head
    initial begin
        logic lastReq;
        req_t e;
        lastReq = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (monitorEnable && (port_req !== lastReq)) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_req: got port_a=0x%0h ds=%b we=%b, expected no request", port_a, port_ds, port_we);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("req_port_a",  32'(port_a),  32'(e.a));
                    checkOutput("req_port_ds", 32'(port_ds), 32'(e.ds));
                    checkOutput("req_port_we", 32'(port_we), 32'(e.we));
                    if (e.we) begin
                        checkOutput("req_port_d", 32'(port_d), 32'(e.d));
                    end
                end
            end
            lastReq = port_req;
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios
    initial begin
        vec_t v;
        reset_n = 1'b0;
        stim    = '0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        checkResetOutputs("por");

        // Release with ack high: SYNC copies the ack, no request follows
        @(posedge clk_sys);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        checkOutput("sync_port_req", 32'(port_req), 32'd1);
        checkOutput("sync_busy",     32'(busy),     32'd0);
        respEnable    = 1'b1;
        monitorEnable = 1'b1;
        @(posedge clk_sys);
        #1;

        // Download byte 0xA5 to 0x0123
        $display("[TB] download write");
        expQ.push_back(mkReq(16'h0091, 2'b10, 1'b1, 16'hA5A5));
        respQ.push_back(16'h0000);
        v = '0; v.dl = 1'b1; v.wr = 1'b1; v.ioAddr = 17'h00123; v.ioData = 8'hA5;
        applyStimulus(v, 1);
        v.wr = 1'b0;
        applyStimulus(v, 1);
        v.dl = 1'b0;
        applyStimulus(v, 1);
        waitIdle("dl_busy_clear", 20);

        // RAM read of 0x1234
        $display("[TB] ram read");
        expQ.push_back(mkReq(16'h891A, 2'b11, 1'b0, 16'h0000));
        respQ.push_back(16'hBEEF);
        v = '0; v.ramCs = 1'b1; v.ramOe = 1'b1; v.ramAd = 16'h1234;
        applyStimulus(v, 1);
        waitIdle("ramrd_busy_clear", 20);
        checkOutput("ram_q_beef", 32'(ram_q), 32'h0000_00EF);
        applyStimulus('0, 2);

        // RAM write and ROM read both pending behind an in-flight RAM read
        $display("[TB] priority ram over rom");
        holdAck = 1'b1;
        expQ.push_back(mkReq(16'h8080, 2'b11, 1'b0, 16'h0000));
        respQ.push_back(16'h7766);
        v = '0; v.ramCs = 1'b1; v.ramOe = 1'b1; v.ramAd = 16'h0100;
        applyStimulus(v, 1);
        applyStimulus('0, 2);
        expQ.push_back(mkReq(16'h8100, 2'b01, 1'b1, 16'h3C3C));
        respQ.push_back(16'h0000);
        expQ.push_back(mkReq(16'h211A, 2'b11, 1'b0, 16'h0000));
        respQ.push_back(16'h5AC3);
        v = '0; v.ramCs = 1'b1; v.ramWe = 1'b1; v.ramAd = 16'h0200; v.ramD = 8'h3C;
        v.romCs = 1'b1; v.atmos = 1'b1; v.romAd = 16'h0235;
        applyStimulus(v, 1);
        v.ramCs = 1'b0; v.ramWe = 1'b0; v.ramAd = 16'h0000; v.ramD = 8'h00;
        applyStimulus(v, 3);
        holdAck = 1'b0;
        waitIdle("prio_busy_clear", 40);
        checkOutput("rom_q_5a", 32'(rom_q), 32'h0000_005A);
        checkOutput("ram_q_after_write", 32'(ram_q), 32'h0000_0066);
        applyStimulus('0, 2);

        // Microdisk ROM at 0x0FFE
        $display("[TB] microdisk rom");
        expQ.push_back(mkReq(16'h47FF, 2'b11, 1'b0, 16'h0000));
        respQ.push_back(16'h12C8);
        v = '0; v.romExtCs = 1'b1; v.romAd = 16'h0FFE;
        applyStimulus(v, 1);
        waitIdle("mdisk_busy_clear", 20);
        checkOutput("rom_q_mdisk", 32'(rom_q), 32'h0000_00C8);
        applyStimulus('0, 2);

        // rom_cs beats rom_ext_cs, Oric-1 bank, top of the 16K window
        $display("[TB] rom select priority");
        expQ.push_back(mkReq(16'h1FFF, 2'b11, 1'b0, 16'h0000));
        respQ.push_back(16'hA19B);
        v = '0; v.romCs = 1'b1; v.romExtCs = 1'b1; v.atmos = 1'b0; v.romAd = 16'h3FFF;
        applyStimulus(v, 1);
        waitIdle("romprio_busy_clear", 20);
        checkOutput("rom_q_oric1", 32'(rom_q), 32'h0000_00A1);
        applyStimulus('0, 2);

        // Core reads during a download are dropped and do not reappear afterwards
        $display("[TB] core ignored during download");
        v = '0; v.dl = 1'b1; v.ramCs = 1'b1; v.ramOe = 1'b1; v.ramAd = 16'h0050;
        applyStimulus(v, 3);
        v.dl = 1'b0;
        applyStimulus(v, 3);
        @(negedge clk_sys);
        checkOutput("dl_ignore_busy", 32'(busy), 32'd0);
        applyStimulus('0, 2);

        // Two ROM address changes while waiting: only the last one issues
        $display("[TB] rom newest wins");
        holdAck = 1'b1;
        expQ.push_back(mkReq(16'h0008, 2'b11, 1'b0, 16'h0000));
        respQ.push_back(16'h4411);
        v = '0; v.romCs = 1'b1; v.romAd = 16'h0010;
        applyStimulus(v, 3);
        v.romAd = 16'h0020;
        applyStimulus(v, 1);
        expQ.push_back(mkReq(16'h0018, 2'b11, 1'b0, 16'h0000));
        respQ.push_back(16'h9922);
        v.romAd = 16'h0031;
        applyStimulus(v, 3);
        holdAck = 1'b0;
        waitIdle("newest_busy_clear", 40);
        checkOutput("rom_q_newest", 32'(rom_q), 32'h0000_0099);
        applyStimulus('0, 2);

        // Reset while a write is in flight and a ROM read is pending
        $display("[TB] reset during wait");
        holdAck = 1'b1;
        expQ.push_back(mkReq(16'h8222, 2'b01, 1'b1, 16'h5555));
        respQ.push_back(16'h0000);
        v = '0; v.ramCs = 1'b1; v.ramWe = 1'b1; v.ramAd = 16'h0444; v.ramD = 8'h55;
        applyStimulus(v, 1);
        v = '0; v.romCs = 1'b1; v.romAd = 16'h0100;
        applyStimulus(v, 3);
        monitorEnable = 1'b0;
        respEnable    = 1'b0;
        reset_n       = 1'b0;
        @(negedge clk_sys);
        checkResetOutputs("midrst");
        respQ.delete();
        applyStimulus('0, 2);
        reset_n = 1'b1;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        checkOutput("resync_req_eq_ack", 32'(port_req), 32'(port_ack));
        checkOutput("resync_busy", 32'(busy), 32'd0);
        holdAck       = 1'b0;
        respEnable    = 1'b1;
        monitorEnable = 1'b1;
        applyStimulus('0, 4);

        checkOutput("exp_queue_drained", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
